mem_arbiter: RTL and testbench

Shares the CPU's single external memory port between instruction fetch (if_stage) and data access (mem_stage). The arbiter accepts one request at a time, drives mem_read/mem_write/mem_addr/mem_write_data toward memory, waits for mem_ack, and returns read data plus a one-cycle acknowledge to the winning requester. It sits between the pipeline stages and the cpu memory ports, and exports its FSM state for the debug hex display.

---
 rtl/mem_arb_if.sv | 30 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Bundle of requester-side and memory-side signals around the shared memory port.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface mem_arb_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_read_data;
    logic [31:0] mem_write_data;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_read_data,
        output i_ack, i_rdata, d_ack, d_rdata, mem_read, mem_write, mem_addr, mem_write_data
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_read_data,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_read, mem_write, mem_addr, mem_write_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one external memory port between instruction fetch and data access.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate winners on ties; default is fixed data priority.
module mem_arbiter (
    input  logic       clk,
    input  logic       reset,
    mem_arb_if.slave   bus,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

    arb_state_t  state_r;
    logic        owner_d_r;
    logic        we_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic        i_ack_r;
    logic        d_ack_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [31:0] i_rdata_r;
    logic [31:0] d_rdata_r;
    logic        grant_d_s;

    // Decide which requester wins when the FSM samples requests in IDLE
    always_comb begin
        grant_d_s = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (bus.d_req && bus.i_req) begin
            grant_d_s = ~owner_d_r;
        end else begin
            grant_d_s = bus.d_req;
        end
`else
        grant_d_s = bus.d_req;
`endif
    end

    // Transaction FSM with all outputs held in registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            owner_d_r   <= 1'b0;
            we_r        <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            i_ack_r     <= 1'b0;
            d_ack_r     <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            i_rdata_r   <= 32'd0;
            d_rdata_r   <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    i_ack_r <= 1'b0;
                    d_ack_r <= 1'b0;
                    if (bus.i_req || bus.d_req) begin
                        owner_d_r   <= grant_d_s;
                        mem_wdata_r <= bus.d_wdata;
                        if (grant_d_s) begin
                            we_r        <= bus.d_we;
                            mem_addr_r  <= bus.d_addr;
                            mem_read_r  <= ~bus.d_we;
                            mem_write_r <= bus.d_we;
                        end else begin
                            we_r        <= 1'b0;
                            mem_addr_r  <= bus.i_addr;
                            mem_read_r  <= 1'b1;
                            mem_write_r <= 1'b0;
                        end
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.mem_ack) begin
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        // Writes leave the rdata registers untouched
                        if (owner_d_r) begin
                            d_ack_r <= 1'b1;
                            if (!we_r) begin
                                d_rdata_r <= bus.mem_read_data;
                            end else begin
                                d_rdata_r <= d_rdata_r;
                            end
                        end else begin
                            i_ack_r   <= 1'b1;
                            i_rdata_r <= bus.mem_read_data;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    i_ack_r <= 1'b0;
                    d_ack_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    i_ack_r     <= 1'b0;
                    d_ack_r     <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign state              = state_r;
    assign bus.i_ack          = i_ack_r;
    assign bus.i_rdata        = i_rdata_r;
    assign bus.d_ack          = d_ack_r;
    assign bus.d_rdata        = d_rdata_r;
    assign bus.mem_read       = mem_read_r;
    assign bus.mem_write      = mem_write_r;
    assign bus.mem_addr       = mem_addr_r;
    assign bus.mem_write_data = mem_wdata_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    logic       clk;
    logic       reset;
    logic [1:0] state;
    mem_arb_if  bus();

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .state (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: one outstanding transaction, acknowledged the cycle after mem_ack
    bit          m_busy, m_done, m_is_d, m_we, m_last_d, m_pick_d;
    logic [1:0]  e_state;
    logic        e_rd, e_wr, e_iack, e_dack;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_last_d = 1'b0; m_we = 1'b0; m_is_d = 1'b0;
            e_rd = 1'b0; e_wr = 1'b0; e_iack = 1'b0; e_dack = 1'b0;
            e_addr = 32'd0; e_wdata = 32'd0; e_irdata = 32'd0; e_drdata = 32'd0;
        end else if (m_done) begin
            m_done = 1'b0;
            e_iack = 1'b0;
            e_dack = 1'b0;
        end else if (m_busy) begin
            if (bus.mem_ack) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                e_rd = 1'b0;
                e_wr = 1'b0;
                if (m_is_d) begin
                    e_dack = 1'b1;
                    if (!m_we) e_drdata = bus.mem_read_data;
                end else begin
                    e_iack = 1'b1;
                    e_irdata = bus.mem_read_data;
                end
            end
        end else if (bus.i_req || bus.d_req) begin
            if (bus.i_req && bus.d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                m_pick_d = !m_last_d;
`else
                m_pick_d = 1'b1;
`endif
            end else begin
                m_pick_d = bus.d_req;
            end
            m_is_d   = m_pick_d;
            m_last_d = m_pick_d;
            m_we     = m_pick_d ? bus.d_we : 1'b0;
            e_addr   = m_pick_d ? bus.d_addr : bus.i_addr;
            e_wdata  = bus.d_wdata;
            e_rd     = !m_we;
            e_wr     = m_we;
            m_busy   = 1'b1;
        end
        e_state = m_busy ? 2'd1 : (m_done ? 2'd2 : 2'd0);
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("m_state", {30'd0, state}, {30'd0, e_state});
            cmp("m_mem_read", {31'd0, bus.mem_read}, {31'd0, e_rd});
            cmp("m_mem_write", {31'd0, bus.mem_write}, {31'd0, e_wr});
            cmp("m_mem_addr", bus.mem_addr, e_addr);
            cmp("m_mem_wdata", bus.mem_write_data, e_wdata);
            cmp("m_i_ack", {31'd0, bus.i_ack}, {31'd0, e_iack});
            cmp("m_d_ack", {31'd0, bus.d_ack}, {31'd0, e_dack});
            cmp("m_i_rdata", bus.i_rdata, e_irdata);
            cmp("m_d_rdata", bus.d_rdata, e_drdata);
            cmp("m_strobe_excl", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    bit stable_ok;
    bit exp_d;

    initial begin
        reset = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = 32'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
        bus.mem_ack = 1'b0; bus.mem_read_data = 32'd0;
        do_reset();
        cmp_en = 1'b1;
        cmp("rst_state", {30'd0, state}, 32'd0);
        cmp("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        cmp("rst_acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
        cmp("rst_addr", bus.mem_addr, 32'd0);
        cmp("rst_i_rdata", bus.i_rdata, 32'd0);

        // Single fetch, memory acks in the second ISSUE cycle
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0040;
        tick();
        cmp("fetch_rd_c1", {31'd0, bus.mem_read}, 32'd1);
        cmp("fetch_addr_c1", bus.mem_addr, 32'h0000_0040);
        cmp("fetch_state_c1", {30'd0, state}, 32'd1);
        tick();
        cmp("fetch_rd_c2", {31'd0, bus.mem_read}, 32'd1);
        bus.mem_ack = 1'b1; bus.mem_read_data = 32'h2402_0005;
        tick();
        bus.mem_ack = 1'b0; bus.i_req = 1'b0;
        cmp("fetch_iack_c3", {31'd0, bus.i_ack}, 32'd1);
        cmp("fetch_rdata_c3", bus.i_rdata, 32'h2402_0005);
        cmp("fetch_rd_c3", {31'd0, bus.mem_read}, 32'd0);
        cmp("fetch_dack_c3", {31'd0, bus.d_ack}, 32'd0);
        tick();
        cmp("fetch_state_c4", {30'd0, state}, 32'd0);
        cmp("fetch_iack_c4", {31'd0, bus.i_ack}, 32'd0);

        // Data write, memory acks immediately
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0100; bus.d_wdata = 32'hDEAD_BEEF;
        bus.mem_read_data = 32'h5555_AAAA;
        tick();
        cmp("wr_mem_write_c1", {31'd0, bus.mem_write}, 32'd1);
        cmp("wr_mem_read_c1", {31'd0, bus.mem_read}, 32'd0);
        cmp("wr_addr_c1", bus.mem_addr, 32'h0000_0100);
        cmp("wr_wdata_c1", bus.mem_write_data, 32'hDEAD_BEEF);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        cmp("wr_dack_c2", {31'd0, bus.d_ack}, 32'd1);
        cmp("wr_drdata_c2", bus.d_rdata, 32'd0);
        cmp("wr_mem_read_c2", {31'd0, bus.mem_read}, 32'd0);
        tick();

        // Tie with both requests held and memory acking every ISSUE cycle
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0400;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0800;
        bus.mem_ack = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            cmp("tie_state_issue", {30'd0, state}, 32'd1);
            tick();
            cmp("tie_state_done", {30'd0, state}, 32'd2);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = (g % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            cmp("tie_d_ack", {31'd0, bus.d_ack}, {31'd0, exp_d});
            cmp("tie_i_ack", {31'd0, bus.i_ack}, {31'd0, !exp_d});
            tick();
            cmp("tie_state_idle", {30'd0, state}, 32'd0);
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b0;
        tick();

        // Stray mem_ack while in DONE and in IDLE
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0080; bus.mem_read_data = 32'h0BAD_F00D;
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.i_req = 1'b0;
        cmp("stray_done_iack", {31'd0, bus.i_ack}, 32'd1);
        tick();
        cmp("stray_done_state", {30'd0, state}, 32'd0);
        cmp("stray_done_acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
        cmp("stray_done_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        tick();
        bus.mem_ack = 1'b0;
        cmp("stray_idle_state", {30'd0, state}, 32'd0);
        cmp("stray_idle_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);

        // Reset while a fetch is in ISSUE
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_00C0; bus.mem_read_data = 32'h1111_2222;
        tick();
        cmp("rst_mid_rd", {31'd0, bus.mem_read}, 32'd1);
        reset = 1'b0; bus.i_req = 1'b0;
        tick();
        reset = 1'b1; bus.mem_ack = 1'b1;
        cmp("rst_mid_rd_after", {31'd0, bus.mem_read}, 32'd0);
        cmp("rst_mid_state", {30'd0, state}, 32'd0);
        cmp("rst_mid_iack", {31'd0, bus.i_ack}, 32'd0);
        tick();
        bus.mem_ack = 1'b0;
        cmp("rst_mid_late_ack_state", {30'd0, state}, 32'd0);
        cmp("rst_mid_late_ack_iack", {31'd0, bus.i_ack}, 32'd0);
        cmp("rst_mid_rdata", bus.i_rdata, 32'd0);

        // Long latency data read: ack arrives in the 20th ISSUE cycle
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0200;
        bus.mem_read_data = 32'h1234_5678;
        stable_ok = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.mem_addr !== 32'h0000_0200 || bus.mem_read !== 1'b1 || bus.d_ack !== 1'b0)
                stable_ok = 1'b0;
            if (c == 20) bus.mem_ack = 1'b1;
        end
        cmp("long_stable", {31'd0, stable_ok}, 32'd1);
        tick();
        bus.mem_ack = 1'b0; bus.d_req = 1'b0;
        cmp("long_dack", {31'd0, bus.d_ack}, 32'd1);
        cmp("long_drdata", bus.d_rdata, 32'h1234_5678);
        tick();
        cmp("long_state_idle", {30'd0, state}, 32'd0);

        // Randomized traffic with stray acks and occasional resets
        for (int n = 0; n < 4000; n++) begin
            tick();
            if (bus.i_req) begin
                if (e_iack) begin
                    bus.i_req = 1'($urandom_range(0, 1));
                    bus.i_addr = $urandom;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.i_req = 1'b1;
                bus.i_addr = $urandom;
            end
            if (bus.d_req) begin
                if (e_dack) begin
                    bus.d_req = 1'($urandom_range(0, 1));
                    bus.d_we = 1'($urandom_range(0, 1));
                    bus.d_addr = $urandom;
                    bus.d_wdata = $urandom;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.d_req = 1'b1;
                bus.d_we = 1'($urandom_range(0, 1));
                bus.d_addr = $urandom;
                bus.d_wdata = $urandom;
            end
            bus.mem_ack = ($urandom_range(0, 2) == 0);
            bus.mem_read_data = $urandom;
            reset = ($urandom_range(0, 199) != 0);
        end
        reset = 1'b1;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
